// File: rtl/fir_pkg.sv
// Shared constants for the fir AXI-Lite configuration master: register map,
// ap_ctrl bit positions and sequencer state codes.
package fir_pkg;

    // fir register map
    localparam int ADDR_AP_CTRL  = 'h00;
    localparam int ADDR_DATA_LEN = 'h10;
    localparam int ADDR_TAP_BASE = 'h20;

    // ap_ctrl bit positions
    localparam int AP_START_BIT = 0;
    localparam int AP_DONE_BIT  = 1;
    localparam int AP_IDLE_BIT  = 2;

    // Sequencer states
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CHK_IDLE = 3'd1;
    localparam logic [2:0] S_WR_LEN   = 3'd2;
    localparam logic [2:0] S_WR_TAP   = 3'd3;
    localparam logic [2:0] S_WR_START = 3'd4;
    localparam logic [2:0] S_POLL     = 3'd5;

endpackage

// File: rtl/fir_cfg_master_if.sv
// AXI-Lite bus between the configuration master and the fir slave port.
// There is no B channel because the fir slave does not implement one.
interface fir_cfg_master_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    logic                   awvalid;
    logic                   awready;
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   wvalid;
    logic                   wready;
    logic [pDATA_WIDTH-1:0] wdata;
    logic                   arvalid;
    logic                   arready;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   rvalid;
    logic                   rready;
    logic [pDATA_WIDTH-1:0] rdata;

    modport master (
        output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        input  awready, wready, arready, rvalid, rdata
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        output awready, wready, arready, rvalid, rdata
    );
endinterface

// File: rtl/fir_cfg_master_xact.sv
// Single AXI-Lite transaction engine: accepts one read or write request at a
// time, runs the handshakes and pulses done_o for one cycle on completion.
module axil_master_xact #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [pADDR_WIDTH-1:0] addr_i,
    input  logic [pDATA_WIDTH-1:0] wdata_i,
    output logic                   done_o,
    output logic [pDATA_WIDTH-1:0] rdata_o,
    fir_cfg_master_if.master       bus
);

    logic                   busy_q,    busy_d;
    logic                   we_q,      we_d;
    logic                   awvalid_q, awvalid_d;
    logic                   wvalid_q,  wvalid_d;
    logic                   arvalid_q, arvalid_d;
    logic                   rready_q,  rready_d;
    logic                   done_q,    done_d;
    logic [pADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [pDATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [pDATA_WIDTH-1:0] rdata_q,   rdata_d;

    // Handshake tracking: each valid drops on its own handshake, and the
    // transaction finishes once every valid it raised has been taken.
    always_comb begin
        busy_d    = busy_q;
        we_d      = we_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        done_d    = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        if (!busy_q) begin
            if (req_i) begin
                busy_d    = 1'b1;
                we_d      = we_i;
                addr_d    = addr_i;
                wdata_d   = wdata_i;
                awvalid_d = we_i;
                wvalid_d  = we_i;
                arvalid_d = !we_i;
            end
        end else if (we_q) begin
            if (awvalid_q && bus.awready) awvalid_d = 1'b0;
            if (wvalid_q && bus.wready)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else begin
            // rready only rises after the address phase, so an rvalid that
            // coincides with arready is left pending at the slave.
            if (arvalid_q && bus.arready) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
            end else if (rready_q && bus.rvalid) begin
                rready_d = 1'b0;
                rdata_d  = bus.rdata;
                busy_d   = 1'b0;
                done_d   = 1'b1;
            end
        end
    end

    // Register all engine state; reset drops every valid immediately.
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            busy_q    <= 1'b0;
            we_q      <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            busy_q    <= busy_d;
            we_q      <= we_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            done_q    <= done_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.awvalid = awvalid_q;
    assign bus.awaddr  = addr_q;
    assign bus.wvalid  = wvalid_q;
    assign bus.wdata   = wdata_q;
    assign bus.arvalid = arvalid_q;
    assign bus.araddr  = addr_q;
    assign bus.rready  = rready_q;
    assign done_o      = done_q;
    assign rdata_o     = rdata_q;

endmodule

// File: rtl/fir_cfg_master.sv
// fir configuration master: checks ap_idle, writes data_length and every tap,
// starts the fir and polls ap_ctrl until ap_done or the poll budget runs out.
module fir_cfg_master
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11,
    parameter int pPOLL_MAX   = 1024
) (
    input  logic                            axis_clk,
    input  logic                            axis_rst,
    input  logic                            cfg_start,
    input  logic [pDATA_WIDTH-1:0]          cfg_len,
    input  logic [Tape_Num*pDATA_WIDTH-1:0] cfg_taps,
    output logic                            cfg_busy,
    output logic                            cfg_done,
    output logic                            cfg_err,
    fir_cfg_master_if.master                bus
);

    localparam int IDX_W  = $clog2(Tape_Num + 1);
    localparam int PCNT_W = $clog2(pPOLL_MAX + 1);

    logic [2:0]                      state_q, state_d;
    logic [IDX_W-1:0]                idx_q,   idx_d;
    logic [PCNT_W-1:0]               poll_q,  poll_d;
    logic [pDATA_WIDTH-1:0]          len_q,   len_d;
    logic [Tape_Num*pDATA_WIDTH-1:0] taps_q,  taps_d;
    logic                            busy_q,  busy_d;
    logic                            done_q,  done_d;
    logic                            err_q,   err_d;

    logic                   x_req;
    logic                   x_we;
    logic [pADDR_WIDTH-1:0] x_addr;
    logic [pDATA_WIDTH-1:0] x_wdata;
    logic                   x_done;
    logic [pDATA_WIDTH-1:0] x_rdata;
    logic                   rdata_unused;

    // Only the status bits of ap_ctrl steer the sequence.
    assign rdata_unused = ^x_rdata;

    axil_master_xact #(
        .pADDR_WIDTH(pADDR_WIDTH),
        .pDATA_WIDTH(pDATA_WIDTH)
    ) u_xact (
        .axis_clk(axis_clk),
        .axis_rst(axis_rst),
        .req_i   (x_req),
        .we_i    (x_we),
        .addr_i  (x_addr),
        .wdata_i (x_wdata),
        .done_o  (x_done),
        .rdata_o (x_rdata),
        .bus     (bus)
    );

    // Request decode per state; held off in the completion cycle so one
    // state never issues the same transaction twice.
    always_comb begin
        x_req   = 1'b0;
        x_we    = 1'b0;
        x_addr  = '0;
        x_wdata = '0;
        case (state_q)
            S_CHK_IDLE, S_POLL: begin
                x_req  = 1'b1;
                x_addr = pADDR_WIDTH'(ADDR_AP_CTRL);
            end
            S_WR_LEN: begin
                x_req   = 1'b1;
                x_we    = 1'b1;
                x_addr  = pADDR_WIDTH'(ADDR_DATA_LEN);
                x_wdata = len_q;
            end
            S_WR_TAP: begin
                x_req   = 1'b1;
                x_we    = 1'b1;
                x_addr  = pADDR_WIDTH'(ADDR_TAP_BASE + 4 * int'(idx_q));
                x_wdata = taps_q[int'(idx_q)*pDATA_WIDTH +: pDATA_WIDTH];
            end
            S_WR_START: begin
                x_req   = 1'b1;
                x_we    = 1'b1;
                x_addr  = pADDR_WIDTH'(ADDR_AP_CTRL);
                x_wdata = pDATA_WIDTH'(1) << AP_START_BIT;
            end
            default: ;
        endcase
        x_req = x_req && !x_done;
    end

    // Sequencer: advances one step per completed transaction.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        poll_d  = poll_q;
        len_d   = len_q;
        taps_d  = taps_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    len_d   = cfg_len;
                    taps_d  = cfg_taps;
                    idx_d   = '0;
                    poll_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S_CHK_IDLE;
                end
            end
            S_CHK_IDLE: begin
                if (x_done) begin
                    if (x_rdata[AP_IDLE_BIT]) begin
                        state_d = S_WR_LEN;
                    end else begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WR_LEN: begin
                if (x_done) state_d = S_WR_TAP;
            end
            S_WR_TAP: begin
                if (x_done) begin
                    if (idx_q == IDX_W'(Tape_Num - 1)) begin
                        idx_d   = '0;
                        state_d = S_WR_START;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_WR_START: begin
                if (x_done) state_d = S_POLL;
            end
            S_POLL: begin
                if (x_done) begin
                    if (x_rdata[AP_DONE_BIT]) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        poll_d = poll_q + PCNT_W'(1);
                        if (poll_d == PCNT_W'(pPOLL_MAX)) begin
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            poll_q  <= '0;
            len_q   <= '0;
            taps_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            poll_q  <= poll_d;
            len_q   <= len_d;
            taps_q  <= taps_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cfg_busy = busy_q;
    assign cfg_done = done_q;
    assign cfg_err  = err_q;

endmodule

// File: tb/tb_fir_cfg_master.sv
// Bench for fir_cfg_master: a behavioural fir AXI-Lite slave records every
// write and read, and each configuration run is compared with the sequence
// expected from the register map and the done/idle responses.
module tb_fir_cfg_master;

    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int NT   = 11;
    localparam int PMAX = 8;

    logic             axis_clk = 1'b0;
    logic             axis_rst;
    logic             cfg_start;
    logic [DW-1:0]    cfg_len;
    logic [NT*DW-1:0] cfg_taps;
    logic             cfg_busy;
    logic             cfg_done;
    logic             cfg_err;

    fir_cfg_master_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus ();

    fir_cfg_master #(
        .pADDR_WIDTH(AW),
        .pDATA_WIDTH(DW),
        .Tape_Num   (NT),
        .pPOLL_MAX  (PMAX)
    ) dut (
        .axis_clk (axis_clk),
        .axis_rst (axis_rst),
        .cfg_start(cfg_start),
        .cfg_len  (cfg_len),
        .cfg_taps (cfg_taps),
        .cfg_busy (cfg_busy),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err),
        .bus      (bus)
    );

    always #5 axis_clk = ~axis_clk;

    int n_chk  = 0;
    int n_fail = 0;

    // slave configuration (written by the main flow only)
    int mode    = 0;     // 0 zero-wait, 1 wready 3 cycles ahead of awready, 2 random
    int done_on = 0;     // poll number that first reports ap_done, 0 = never
    bit idle_cfg = 1'b1;
    int clr_req = 0;

    // scoreboard (written by the slave process only)
    int clr_ack = 0;
    logic [AW-1:0] aw_q[$];
    logic [DW-1:0] w_q[$];
    logic [AW-1:0] ar_q[$];
    int done_cnt, err_cnt, both_cnt, busy_pulse, aw_hold, first_ev, poll_n;
    bit start_seen;

    int taps[NT];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural fir slave and monitor; drives readies/rvalid on the falling
    // edge and records the handshakes that the next rising edge will complete.
    initial begin : slave
        int aw_age, w_age, rd_wait;
        bit last_ar, last_r, rd_pend;
        logic [DW-1:0] rval;
        aw_age = 0; w_age = 0; rd_wait = 0;
        last_ar = 0; last_r = 0; rd_pend = 0; rval = '0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
        bus.rvalid = 1'b0; bus.rdata = '0;
        forever begin
            @(negedge axis_clk);
            if (clr_ack != clr_req) begin
                aw_q.delete(); w_q.delete(); ar_q.delete();
                done_cnt = 0; err_cnt = 0; both_cnt = 0; busy_pulse = 0;
                aw_hold = 0; first_ev = 0; poll_n = 0; start_seen = 0;
                clr_ack = clr_req;
            end
            if (axis_rst) begin
                bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
                bus.rvalid = 1'b0; bus.rdata = '0;
                rd_pend = 0; last_ar = 0; last_r = 0; aw_age = 0; w_age = 0;
            end else begin
                if (last_r) bus.rvalid = 1'b0;
                if (last_ar) begin
                    rd_pend = 1;
                    rd_wait = (mode == 2) ? int'($urandom_range(0, 3)) : 0;
                    if (start_seen) begin
                        poll_n++;
                        rval = (done_on != 0 && poll_n >= done_on) ? 32'h2 : 32'h0;
                    end else begin
                        rval = idle_cfg ? 32'h4 : 32'h0;
                    end
                end
                if (rd_pend) begin
                    if (rd_wait == 0) begin
                        bus.rvalid = 1'b1;
                        bus.rdata  = rval;
                        rd_pend    = 0;
                    end else begin
                        rd_wait--;
                    end
                end
                if (bus.awvalid) begin
                    bus.awready = (mode == 2) ? ($urandom_range(0, 1) == 1) : (aw_age >= ((mode == 1) ? 3 : 0));
                    aw_age++;
                end else begin
                    bus.awready = 1'b0;
                    aw_age = 0;
                end
                if (bus.wvalid) begin
                    bus.wready = (mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b1;
                    w_age++;
                end else begin
                    bus.wready = 1'b0;
                    w_age = 0;
                end
                bus.arready = bus.arvalid && ((mode != 2) || ($urandom_range(0, 1) == 1));

                last_ar = bus.arvalid && bus.arready;
                last_r  = bus.rvalid && bus.rready;
                if (last_ar) begin
                    ar_q.push_back(bus.araddr);
                    if (first_ev == 0) first_ev = 1;
                end
                if (bus.awvalid && bus.awready) begin
                    aw_q.push_back(bus.awaddr);
                    if (first_ev == 0) first_ev = 2;
                    if (bus.awaddr == '0) start_seen = 1;
                end
                if (bus.wvalid && bus.wready) w_q.push_back(bus.wdata);
                if (bus.awvalid && !bus.wvalid) aw_hold++;
                if (cfg_done) done_cnt++;
                if (cfg_err) err_cnt++;
                if (cfg_done && cfg_err) both_cnt++;
                if ((cfg_done || cfg_err) && cfg_busy) busy_pulse++;
            end
        end
    end

    task automatic clear_sb();
        clr_req++;
        wait (clr_ack == clr_req);
    endtask

    task automatic start_cfg(input logic [31:0] len);
        for (int i = 0; i < NT; i++) cfg_taps[i*DW +: DW] = taps[i];
        clear_sb();
        cfg_len   = len;
        cfg_start = 1'b1;
        @(negedge axis_clk);
        cfg_start = 1'b0;
        // inputs are only sampled at acceptance; scramble them afterwards
        cfg_len = $urandom;
        for (int i = 0; i < NT; i++) cfg_taps[i*DW +: DW] = $urandom;
    endtask

    task automatic run_cfg(input logic [31:0] len, input int d_on, input bit idle,
                           input int md, input bit dbl);
        int cyc, exp_nw, exp_rd, nbad;
        bit exp_done;
        logic [31:0] ea, ed;
        mode = md; done_on = d_on; idle_cfg = idle;
        start_cfg(len);
        chk("busy_after_start", 32'(cfg_busy), 32'd1);
        cyc = 0;
        while (done_cnt + err_cnt == 0 && cyc < 4000) begin
            @(negedge axis_clk);
            cyc++;
            cfg_start = dbl && (cyc == 8);
            if (dbl && cyc == 8) cfg_len = len ^ 32'h0000_FFFF;
        end
        cfg_start = 1'b0;
        chk("pulse_seen", 32'(done_cnt + err_cnt != 0), 32'd1);
        repeat (6) @(negedge axis_clk);

        // reference: what the fir should have seen for this configuration
        exp_done = idle && d_on >= 1 && d_on <= PMAX;
        exp_nw   = idle ? NT + 2 : 0;
        exp_rd   = !idle ? 1 : (exp_done ? 1 + d_on : 1 + PMAX);

        chk("done_cycles", done_cnt, 32'(exp_done));
        chk("err_cycles", err_cnt, 32'(!exp_done));
        chk("done_err_overlap", both_cnt, 0);
        chk("busy_at_pulse", busy_pulse, 0);
        chk("first_op_is_read", first_ev, 1);
        chk("aw_count", aw_q.size(), exp_nw);
        chk("w_count", w_q.size(), exp_nw);
        chk("ar_count", ar_q.size(), exp_rd);
        nbad = 0;
        foreach (ar_q[i]) if (ar_q[i] != '0) nbad++;
        chk("ar_addr_ctrl", nbad, 0);
        for (int i = 0; i < exp_nw; i++) begin
            if (i == 0) begin
                ea = 32'h10; ed = len;
            end else if (i <= NT) begin
                ea = 32'h20 + 32'(4 * (i - 1)); ed = 32'(taps[i-1]);
            end else begin
                ea = 32'h0; ed = 32'h1;
            end
            if (i < aw_q.size()) chk($sformatf("wr_addr%0d", i), 32'(aw_q[i]), ea);
            if (i < w_q.size())  chk($sformatf("wr_data%0d", i), w_q[i], ed);
        end
        if (md == 1 && exp_nw > 0) chk("aw_held_after_w", 32'(aw_hold > 0), 32'd1);
        chk("idle_not_busy", 32'(cfg_busy), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;
        axis_rst  = 1'b1;
        cfg_start = 1'b0;
        cfg_len   = '0;
        cfg_taps  = '0;
        repeat (3) @(negedge axis_clk);
        chk("rst_ctrl", 32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.rready,
                             cfg_busy, cfg_done, cfg_err}), 32'd0);
        chk("rst_awaddr", 32'(bus.awaddr), 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);
        axis_rst = 1'b0;
        repeat (2) @(negedge axis_clk);

        // reference coefficients, zero-wait slave, ap_done on 3rd poll
        taps = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
        run_cfg(32'd600, 3, 1'b1, 0, 1'b0);

        // wready arrives 3 cycles ahead of awready on every write
        for (int i = 0; i < NT; i++) taps[i] = int'($urandom);
        run_cfg($urandom, 2, 1'b1, 1, 1'b0);

        // fir not idle at start
        run_cfg(32'd77, 1, 1'b0, 0, 1'b0);

        // ap_done never reported: poll budget exhausted
        run_cfg(32'd5, 0, 1'b1, 0, 1'b0);

        // reset in the middle of a tap write
        mode = 0; done_on = 3; idle_cfg = 1'b1;
        start_cfg(32'd42);
        cyc = 0;
        while (!(bus.awvalid && bus.awaddr >= 12'h24) && cyc < 200) begin
            @(negedge axis_clk);
            cyc++;
        end
        chk("tap_write_reached", 32'(bus.awvalid), 32'd1);
        #2 axis_rst = 1'b1;
        #1 chk("rst_drops_valids", 32'({bus.awvalid, bus.wvalid, bus.arvalid, cfg_busy}), 32'd0);
        repeat (2) @(negedge axis_clk);
        axis_rst = 1'b0;
        @(negedge axis_clk);
        run_cfg(32'd900, 4, 1'b1, 0, 1'b0);

        // second start while busy must be ignored
        run_cfg(32'd1234, 2, 1'b1, 0, 1'b1);

        // randomized configurations and slave timing
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < NT; i++) taps[i] = int'($urandom);
            run_cfg($urandom, int'($urandom_range(0, PMAX)), ($urandom_range(0, 4) != 0),
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_cfg_master.md
Name: fir_cfg_master

Overview:
- AXI-Lite initiator that programs and launches the fir block: writes data_length, all Tape_Num tap coefficients, then ap_start, and polls ap_ctrl until ap_done.
- Sits between the testbench or the SoC control logic and the fir AXI-Lite slave port.
- Drives the other end of the fir AXI-Lite interface. It has no B channel, because that interface has none.

Parameters:
- pADDR_WIDTH, 12, AXI-Lite address width.
- pDATA_WIDTH, 32, AXI-Lite data width.
- Tape_Num, 11, number of tap coefficients written.
- pPOLL_MAX, 1024, maximum ap_ctrl reads while waiting for ap_done before declaring an error.

Ports:
- axis_clk  in  1  clock.
- axis_rst  in  1  asynchronous reset, active-high.
- cfg_start  in  1  one-cycle request to start a configuration sequence; ignored while cfg_busy=1.
- cfg_len  in  32  data_length value; sampled when cfg_start is accepted.
- cfg_taps  in  Tape_Num*32  coefficients; tap i is bits [32*i+31:32*i]; sampled when cfg_start is accepted.
- cfg_busy  out  1  high from the cycle after start acceptance until the final state.
- cfg_done  out  1  one-cycle pulse when ap_done is observed.
- cfg_err  out  1  one-cycle pulse when the fir is not idle at start, or on poll timeout.
- awvalid  out  1  write-address valid.
- awready  in  1  write-address ready.
- awaddr  out  pADDR_WIDTH  write address.
- wvalid  out  1  write-data valid.
- wready  in  1  write-data ready.
- wdata  out  pDATA_WIDTH  write data.
- arvalid  out  1  read-address valid.
- arready  in  1  read-address ready.
- araddr  out  pADDR_WIDTH  read address.
- rvalid  in  1  read-data valid.
- rready  out  1  read-data ready.
- rdata  in  pDATA_WIDTH  read data.

Behaviour:
- Address map (decided): ap_ctrl 0x00; bit0 ap_start, bit1 ap_done, bit2 ap_idle. data_length 0x10. Tap i at 0x20+4*i.
- Reset: all outputs 0, FSM in IDLE, tap index 0, poll counter 0. A reset mid-transaction drops valid signals immediately; no completion is owed to the slave.
- FSM states and transitions:
  - IDLE: on cfg_start, latch cfg_len and cfg_taps, go to CHK_IDLE.
  - CHK_IDLE: read ap_ctrl. If rdata[2]=1, go to WR_LEN. Otherwise pulse cfg_err and go to IDLE.
  - WR_LEN: write cfg_len to 0x10, then go to WR_TAP.
  - WR_TAP: write tap[idx] to 0x20+4*idx. After the write completes, idx++. When idx reaches Tape_Num, go to WR_START.
  - WR_START: write 0x0000_0001 to 0x00, then go to POLL.
  - POLL: read 0x00.
    - rdata[1]=1: pulse cfg_done, go to IDLE.
    - Otherwise poll_cnt++. When poll_cnt reaches pPOLL_MAX, pulse cfg_err and go to IDLE.
    - Otherwise reissue the read on the next cycle.
- Write transaction:
  - Entering a write state sets awvalid and wvalid together in the same cycle, with addr and data stable.
  - awvalid drops in the cycle after its own awvalid&&awready handshake; wvalid likewise after wvalid&&wready. The two handshakes may occur in either order or in the same cycle.
  - The write completes when both handshakes have occurred; the next state is entered the following cycle.
  - awaddr and wdata stay stable until both handshakes are done.
- Read transaction:
  - arvalid=1 with araddr stable until arvalid&&arready. In the next cycle, arvalid=0 and rready=1.
  - rdata is sampled on rvalid&&rready, then rready drops.
  - rvalid arriving in the same cycle as arready is not accepted (rready is still 0); the slave holds it.
- Minimum latency per write is 2 cycles (valid asserted, then both readies). With zero-wait slaves, a full sequence takes 1 read + (Tape_Num+2) writes + N polls.
- Outputs are registered; no combinational path from any ready or valid input to any output.
- cfg_start while busy is ignored: it is not queued and raises no error.
- cfg_done and cfg_err are never asserted in the same cycle.
- cfg_busy is 0 in IDLE and in the cycle cfg_done or cfg_err pulses.

Decomposition:
- Shared package fir_pkg: address constants (ADDR_AP_CTRL=0x00, ADDR_DATA_LEN=0x10, ADDR_TAP_BASE=0x20), ap_ctrl bit indices, FSM state enum.
- One sub-module, axil_master_xact: the single write/read handshake engine, with req/we/addr/wdata in and done/rdata out. The top-level FSM sequences requests through it.

Test Plan:
- Zero-wait slave, ap_idle=1, cfg_len=600, taps 0..10 = {0,-10,-9,23,56,63,56,23,-9,-10,0} -> writes observed in order: 0x10=600, 0x20..0x48 = taps, 0x00=1. ap_done on the 3rd poll gives exactly 3 reads after the start write, then cfg_done pulses for 1 cycle.
- Slave asserts wready 3 cycles before awready on every write -> wvalid drops first, awvalid holds, each write completes only after both handshakes, data is not duplicated, tap order is preserved.
- Slave returns ap_ctrl=0x0 (not idle) at start -> zero writes issued, cfg_err pulses 1 cycle, back in IDLE.
- ap_done never set, pPOLL_MAX=8 -> exactly 8 reads of 0x00, then cfg_err pulses, cfg_done stays 0.
- axis_rst asserted while awvalid=1 mid-tap write -> awvalid, wvalid, cfg_busy drop immediately. A new cfg_start after reset restarts from CHK_IDLE.
- cfg_start pulsed again while busy, with different cfg_len -> ignored; the original value is written and only one cfg_done pulses.
